// File: rtl/i2c_wr_master.sv
// i2c_wr_master
//   Byte-level I2C write master for the camera register-configuration
//   sequencer. One accepted 32-bit word {dev_addr, reg_addr[15:0], reg_val}
//   is sent as a 16-bit-subaddress write: START, 4 bytes MSB-first, each
//   followed by an ACK slot, then STOP. A NACK aborts the remaining bytes.
//   SCL timing comes from a quarter-period tick divider in the clk_25M domain.
//
// Ports
//   clk_25M    in     system clock
//   camera_rst in     synchronous active-high reset
//   start      in     request level, held high until tr_end is seen
//   i2c_data   in     {dev_addr, reg_addr_hi, reg_addr_lo, reg_val}
//   tr_end     out    transaction finished, held while start stays high
//   ack_err    out    a NACK ended the last transaction (valid with tr_end)
//   busy       out    high from acceptance until return to idle
//   i2c_sclk   out    SCL, push-pull
//   i2c_sdat   inout  SDA, open-drain (driven 0 or released)
module i2c_wr_master #(
  parameter int unsigned CLK_DIV = 312,
  parameter int unsigned NBYTES  = 4
) (
  input  logic        clk_25M,
  input  logic        camera_rst,
  input  logic        start,
  input  logic [31:0] i2c_data,
  output logic        tr_end,
  output logic        ack_err,
  output logic        busy,
  output logic        i2c_sclk,
  inout  wire         i2c_sdat
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BIT,
    S_ACK,
    S_STOP,
    S_DONE
  } state_t;

  localparam logic [15:0] DIV_MAX   = 16'(CLK_DIV - 1);
  localparam logic [1:0]  LAST_BYTE = 2'(NBYTES - 1);

  state_t      state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [1:0]  phase_q, phase_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic [31:0] shreg_q, shreg_d;
  logic        scl_q, scl_d;
  logic        sda_oe_q, sda_oe_d;
  logic        ack_bit_q, ack_bit_d;
  logic        tr_end_q, tr_end_d;
  logic        busy_q, busy_d;
  logic        ack_err_q, ack_err_d;
  logic        sda_meta, sda_in;
  logic        tick;

  // SDA is only ever pulled low; a released line reads back through the
  // external pull-up.
  assign i2c_sdat = sda_oe_q ? 1'b0 : 1'bz;

  // Two-flop synchroniser on the returning SDA; the ACK sample happens a
  // full tick after SCL rises, so the added latency is invisible.
  always_ff @(posedge clk_25M) begin
    if (camera_rst) begin
      sda_meta <= 1'b1;
      sda_in   <= 1'b1;
    end else begin
      sda_meta <= i2c_sdat;
      sda_in   <= sda_meta;
    end
  end

  assign tick = (div_q == DIV_MAX);

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    shreg_d   = shreg_q;
    scl_d     = scl_q;
    sda_oe_d  = sda_oe_q;
    ack_bit_d = ack_bit_q;
    tr_end_d  = tr_end_q;
    busy_d    = busy_q;
    ack_err_d = ack_err_q;

    if (state_q == S_IDLE || state_q == S_DONE) begin
      div_d = '0;
    end else begin
      div_d = tick ? '0 : div_q + 16'd1;
    end

    // Every protocol state is four ticks long; phase wraps 3 -> 0 on its own.
    if (tick) begin
      phase_d = phase_q + 2'd1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          shreg_d   = i2c_data;
          busy_d    = 1'b1;
          ack_err_d = 1'b0;
          bit_d     = '0;
          byte_d    = '0;
          phase_d   = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          unique case (phase_q)
            2'd0: sda_oe_d = 1'b1;
            2'd1: ;
            2'd2: scl_d = 1'b0;
            2'd3: state_d = S_BIT;
          endcase
        end
      end
      S_BIT: begin
        if (tick) begin
          unique case (phase_q)
            2'd0: sda_oe_d = ~shreg_q[31];
            2'd1: scl_d = 1'b1;
            2'd2: ;
            2'd3: begin
              scl_d   = 1'b0;
              shreg_d = {shreg_q[30:0], 1'b0};
              bit_d   = bit_q + 3'd1;
              if (bit_q == 3'd7) begin
                state_d = S_ACK;
              end
            end
          endcase
        end
      end
      S_ACK: begin
        if (tick) begin
          unique case (phase_q)
            2'd0: sda_oe_d = 1'b0;
            2'd1: scl_d = 1'b1;
            2'd2: ack_bit_d = sda_in;
            2'd3: begin
              scl_d = 1'b0;
              if (ack_bit_q) begin
                ack_err_d = 1'b1;
                state_d   = S_STOP;
              end else if (byte_q == LAST_BYTE) begin
                state_d = S_STOP;
              end else begin
                byte_d  = byte_q + 2'd1;
                state_d = S_BIT;
              end
            end
          endcase
        end
      end
      S_STOP: begin
        if (tick) begin
          unique case (phase_q)
            2'd0: sda_oe_d = 1'b1;
            2'd1: scl_d = 1'b1;
            2'd2: sda_oe_d = 1'b0;
            2'd3: state_d = S_DONE;
          endcase
        end
      end
      S_DONE: begin
        tr_end_d = 1'b1;
        if (!start) begin
          tr_end_d = 1'b0;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_25M) begin
    if (camera_rst) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      phase_q   <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      shreg_q   <= '0;
      scl_q     <= 1'b1;
      sda_oe_q  <= 1'b0;
      ack_bit_q <= 1'b0;
      tr_end_q  <= 1'b0;
      busy_q    <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      shreg_q   <= shreg_d;
      scl_q     <= scl_d;
      sda_oe_q  <= sda_oe_d;
      ack_bit_q <= ack_bit_d;
      tr_end_q  <= tr_end_d;
      busy_q    <= busy_d;
      ack_err_q <= ack_err_d;
    end
  end

  assign tr_end   = tr_end_q;
  assign busy     = busy_q;
  assign ack_err  = ack_err_q;
  assign i2c_sclk = scl_q;

endmodule

// File: tb/tb_i2c_wr_master.sv
// Bench for i2c_wr_master: a bus monitor decodes START/STOP/bytes/ACK bits
// from the wires and acts as a slave that ACKs every byte except an optional
// chosen one. Expected frames and latencies come from byte counts alone.
module tb_i2c_wr_master;

  localparam int unsigned CLK_DIV = 4;
  localparam int LIMIT = 160 * CLK_DIV + 50;

  logic        clk_25M    = 1'b0;
  logic        camera_rst = 1'b1;
  logic        start      = 1'b0;
  logic [31:0] i2c_data   = '0;
  logic        tr_end, ack_err, busy, i2c_sclk;
  logic        sda_drv    = 1'b0;
  wire         sda;

  assign sda = sda_drv ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_wr_master #(.CLK_DIV(CLK_DIV), .NBYTES(4)) dut (
    .clk_25M   (clk_25M),
    .camera_rst(camera_rst),
    .start     (start),
    .i2c_data  (i2c_data),
    .tr_end    (tr_end),
    .ack_err   (ack_err),
    .busy      (busy),
    .i2c_sclk  (i2c_sclk),
    .i2c_sdat  (sda)
  );

  always #5 clk_25M = ~clk_25M;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- bus monitor / slave ----------------
  logic       scl_p = 1'b1, sda_p = 1'b1;
  int         bitpos = 0, byte_idx = 0, n_start = 0, n_stop = 0;
  int         nack_idx = 99;
  logic [7:0] cur = '0;
  logic [7:0] mon_bytes[$];
  logic       mon_acks[$];

  always @(negedge clk_25M) begin
    logic c, s;
    c = (i2c_sclk === 1'b1);
    s = (sda !== 1'b0);
    if (camera_rst) begin
      sda_drv = 1'b0;
    end else begin
      if (scl_p && c) begin
        if (sda_p && !s) begin
          n_start++;
          bitpos   = 0;
          byte_idx = 0;
        end else if (!sda_p && s) begin
          n_stop++;
        end
      end
      if (!scl_p && c) begin
        if (bitpos < 8) begin
          cur = {cur[6:0], s};
          bitpos++;
        end else begin
          mon_bytes.push_back(cur);
          mon_acks.push_back(s);
          bitpos = 0;
          byte_idx++;
        end
      end
      if (scl_p && !c) sda_drv = (bitpos == 8) && (byte_idx != nack_idx);
    end
    scl_p = c;
    sda_p = s;
  end

  // ---------------- transaction driver ----------------
  int         obs_lat, obs_starts, obs_stops;
  logic       obs_aerr, obs_busy;
  logic [7:0] obs_bytes[$];
  logic       obs_acks[$];

  task automatic do_txn(input logic [31:0] data, input int nack);
    int nb0, ns0, np0, cyc;
    nack_idx = nack;
    nb0 = mon_bytes.size();
    ns0 = n_start;
    np0 = n_stop;
    i2c_data = data;
    start = 1'b1;
    cyc = 0;
    obs_busy = 1'b0;
    do begin
      @(posedge clk_25M); #1;
      cyc++;
      if (cyc == 1) begin
        obs_busy = busy;
        i2c_data = $urandom;  // must be ignored after acceptance
      end
    end while (tr_end !== 1'b1 && cyc < LIMIT);
    obs_lat    = (tr_end === 1'b1) ? cyc - 1 : -1;
    obs_aerr   = ack_err;
    obs_starts = n_start - ns0;
    obs_stops  = n_stop - np0;
    obs_bytes.delete();
    obs_acks.delete();
    for (int i = nb0; i < mon_bytes.size(); i++) begin
      obs_bytes.push_back(mon_bytes[i]);
      obs_acks.push_back(mon_acks[i]);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    camera_rst = 1'b1;
    repeat (3) @(posedge clk_25M);
    #1;
    n_tests++; if (i2c_sclk !== 1'b1) begin n_fail++; $display("FAIL reset_scl: got %b expected 1", i2c_sclk); end
    n_tests++; if (sda !== 1'b1) begin n_fail++; $display("FAIL reset_sda: got %b expected 1 (released)", sda); end
    n_tests++; if (tr_end !== 1'b0) begin n_fail++; $display("FAIL reset_tr_end: got %b expected 0", tr_end); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (ack_err !== 1'b0) begin n_fail++; $display("FAIL reset_ack_err: got %b expected 0", ack_err); end
    camera_rst = 1'b0;
    @(posedge clk_25M); #1;
  endtask

  task automatic test_write(input string name, input logic [31:0] data, input int nack, input bit hold);
    int   exp_n, exp_lat;
    logic exp_aerr;
    logic [7:0] eb;
    exp_aerr = (nack >= 0 && nack < 4);
    exp_n    = exp_aerr ? nack + 1 : 4;
    exp_lat  = (4 + 36 * exp_n + 4) * CLK_DIV + 1;
    do_txn(data, nack);
    n_tests++; if (obs_lat != exp_lat) begin n_fail++; $display("FAIL %s latency: got %0d expected %0d", name, obs_lat, exp_lat); end
    n_tests++; if (obs_busy !== 1'b1) begin n_fail++; $display("FAIL %s busy_after_accept: got %b expected 1", name, obs_busy); end
    n_tests++; if (obs_aerr !== exp_aerr) begin n_fail++; $display("FAIL %s ack_err: got %b expected %b", name, obs_aerr, exp_aerr); end
    n_tests++; if (obs_bytes.size() != exp_n) begin n_fail++; $display("FAIL %s byte_count: got %0d expected %0d", name, obs_bytes.size(), exp_n); end
    for (int i = 0; i < exp_n && i < obs_bytes.size(); i++) begin
      eb = data[31 - 8 * i -: 8];
      n_tests++; if (obs_bytes[i] !== eb) begin n_fail++; $display("FAIL %s byte%0d: got %h expected %h", name, i, obs_bytes[i], eb); end
      n_tests++; if (obs_acks[i] !== (i == nack)) begin n_fail++; $display("FAIL %s ack%0d: got %b expected %b", name, i, obs_acks[i], (i == nack)); end
    end
    n_tests++; if (obs_starts != 1 || obs_stops != 1) begin n_fail++; $display("FAIL %s start_stop: got %0d/%0d expected 1/1", name, obs_starts, obs_stops); end
    if (!hold) begin
      start = 1'b0;
      @(posedge clk_25M); #1;
      n_tests++; if (tr_end !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL %s release: got tr_end=%b busy=%b expected 0/0", name, tr_end, busy); end
    end
  endtask

  task automatic test_handshake;
    int   ns0;
    logic bad;
    ns0 = n_start;
    bad = 1'b0;
    repeat (40) begin
      @(posedge clk_25M); #1;
      if (tr_end !== 1'b1 || busy !== 1'b1 || i2c_sclk !== 1'b1) bad = 1'b1;
    end
    n_tests++; if (bad || n_start != ns0) begin n_fail++; $display("FAIL hs_hold: got bad=%b new_starts=%0d expected 0/0", bad, n_start - ns0); end
    start = 1'b0;
    @(posedge clk_25M); #1;
    n_tests++; if (tr_end !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL hs_drop: got tr_end=%b busy=%b expected 0/0", tr_end, busy); end
  endtask

  task automatic test_reset_mid;
    int   nb0, np0, ns1, cyc;
    logic bad;
    nack_idx = 99;
    nb0 = mon_bytes.size();
    np0 = n_stop;
    i2c_data = 32'h78310311;
    start = 1'b1;
    cyc = 0;
    while (!(mon_bytes.size() >= nb0 + 1 && bitpos >= 3) && cyc < LIMIT) begin
      @(posedge clk_25M); #1;
      cyc++;
    end
    n_tests++; if (cyc >= LIMIT) begin n_fail++; $display("FAIL rstmid_reach: got timeout expected byte 2 in flight"); end
    camera_rst = 1'b1;
    start = 1'b0;
    @(posedge clk_25M); #1;
    n_tests++; if (i2c_sclk !== 1'b1 || sda !== 1'b1) begin n_fail++; $display("FAIL rstmid_bus: got scl=%b sda=%b expected 1/1", i2c_sclk, sda); end
    n_tests++; if (busy !== 1'b0 || tr_end !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags: got busy=%b tr_end=%b expected 0/0", busy, tr_end); end
    camera_rst = 1'b0;
    ns1 = n_start;
    bad = 1'b0;
    repeat (20) begin
      @(posedge clk_25M); #1;
      if (i2c_sclk !== 1'b1 || sda !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    n_tests++; if (bad || n_start != ns1 || n_stop != np0) begin n_fail++; $display("FAIL rstmid_idle: got bad=%b starts=%0d stops=%0d expected 0/0/0", bad, n_start - ns1, n_stop - np0); end
  endtask

  initial begin
    logic [31:0] d;
    int          nk;
    test_reset();
    test_write("nominal",   32'h78310311, 99, 1'b0);
    test_write("addr_nack", 32'h78310311, 0,  1'b0);
    test_write("data_nack", 32'h78310311, 2,  1'b0);
    test_write("hs_first",  32'h78310311, 99, 1'b1);
    test_handshake();
    test_write("hs_second", 32'h78300882, 99, 1'b0);
    test_reset_mid();
    test_write("post_reset", 32'h78310311, 99, 1'b0);
    for (int i = 0; i < 8; i++) begin
      d  = $urandom;
      nk = $urandom_range(0, 5);
      test_write($sformatf("rand%0d", i), d, nk, 1'b0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
